// File: rtl/seg7_dec_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
// The error counter is included only when SEG7_DEC_ERRCNT_EN is defined (see seg7_scan_decoder).
package seg7_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } seg7_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment patterns, bit6=a .. bit0=g; entry i displays hex digit i
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  // Position of the single low bit in an enable word (caller guarantees one-hot-low)
  function automatic logic [2:0] sel_index(input logic [7:0] en);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!en[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decode of an active-low segment pattern to a hex nibble.
// ok is low for any pattern outside the hex table, including SEG_BLANK.
module seg7_to_hex
  import seg7_dec_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       ok
);

  always_comb begin
    nibble = 4'd0;
    ok     = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        nibble = 4'(i);
        ok     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers an 8-digit hex value from a multiplexed, active-low 7-segment scan bus.
// Define SEG7_DEC_ERRCNT_EN to build the saturating undecodable-pattern counter.
//
// Handshake: valid is a one-cycle pulse; value and frame_err are meaningful on that
// cycle and hold until the next pulse. There is no back-pressure.
module seg7_scan_decoder
  import seg7_dec_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [6:0]  seg_in,
  input  logic [7:0]  en_in,
  output logic [31:0] value,
  output logic        valid,
  output logic        frame_err,
  output logic [7:0]  digit_mask,
  output logic [7:0]  err_count,
  output logic [1:0]  state
);

  localparam logic [8:0] STABLE_LAST = 9'(STABLE_CYCLES);
  localparam logic       ONE_CYCLE   = (STABLE_LAST == 9'd1);

  seg7_state_e cur_state, nxt_state;
  logic [7:0]  cnt, cnt_nxt;
  logic [7:0]  reg_en;
  logic [6:0]  reg_seg;
  logic [31:0] shadow;
  logic        frame_flag;

  logic        sel, same, capture, frame_done;
  logic [2:0]  idx;
  logic [3:0]  dec_nibble;
  logic        dec_ok;
  logic [7:0]  mask_nxt;
  logic        flag_nxt;

  assign sel        = $onehot(~en_in);
  assign same       = (en_in == reg_en) && (seg_in == reg_seg);
  assign idx        = sel_index(en_in);
  assign frame_done = (digit_mask == 8'hFF);
  assign state      = cur_state;

  seg7_to_hex u_dec (
    .seg    (seg_in),
    .nibble (dec_nibble),
    .ok     (dec_ok)
  );

  // Counter holds the number of consecutive cycles the registered pair has been seen
  always_comb begin
    nxt_state = cur_state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (sel) begin
          cnt_nxt   = 8'd1;
          capture   = ONE_CYCLE;
          nxt_state = ONE_CYCLE ? ST_HOLD : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!sel) begin
          nxt_state = ST_IDLE;
        end else if (same) begin
          cnt_nxt = 8'(cnt + 8'd1);
          if (({1'b0, cnt} + 9'd1) == STABLE_LAST) begin
            capture   = 1'b1;
            nxt_state = ST_HOLD;
          end
        end else begin
          cnt_nxt   = 8'd1;
          capture   = ONE_CYCLE;
          nxt_state = ONE_CYCLE ? ST_HOLD : ST_SETTLE;
        end
      end
      ST_HOLD: begin
        if (!sel) begin
          nxt_state = ST_IDLE;
        end else if (!same) begin
          cnt_nxt   = 8'd1;
          capture   = ONE_CYCLE;
          nxt_state = ONE_CYCLE ? ST_HOLD : ST_SETTLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // A capture on the frame-completion clock already belongs to the next frame
  always_comb begin
    mask_nxt = frame_done ? 8'd0 : digit_mask;
    flag_nxt = frame_done ? 1'b0 : frame_flag;
    if (capture) begin
      mask_nxt = mask_nxt | (8'd1 << idx);
      flag_nxt = flag_nxt | !dec_ok;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cur_state  <= ST_IDLE;
      cnt        <= 8'd0;
      reg_en     <= 8'hFF;
      reg_seg    <= SEG_BLANK;
      shadow     <= 32'd0;
      frame_flag <= 1'b0;
      digit_mask <= 8'd0;
      value      <= 32'd0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      cnt        <= cnt_nxt;
      digit_mask <= mask_nxt;
      frame_flag <= flag_nxt;
      valid      <= frame_done;
      if (sel) begin
        reg_en  <= en_in;
        reg_seg <= seg_in;
      end
      if (frame_done) begin
        value     <= shadow;
        frame_err <= frame_flag;
      end
      if (capture && dec_ok) begin
        shadow[{idx, 2'b00} +: 4] <= dec_nibble;
      end
    end
  end

`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      err_cnt_q <= 8'd0;
    end else if (capture && !dec_ok && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= 8'(err_cnt_q + 8'd1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured, legal range 1..255.
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port seg_in  input  7  segment lines, active-low, bit6=a .. bit0=g.
REQ-005 SHALL have port en_in  input  8  digit enables, active-low, bit k selects digit k.
REQ-006 SHALL have port value  output  32  last complete frame, digit k in bits [4k+3:4k].
REQ-007 SHALL have port valid  output  1  one-cycle pulse when value updates.
REQ-008 SHALL have port frame_err  output  1  qualified by valid: frame contained an undecodable pattern.
REQ-009 SHALL have port digit_mask  output  8  digits captured so far in the current frame.
REQ-010 SHALL have port err_count  output  8  invalid-pattern count (see Configuration).

Function
REQ-011 SHALL treat en_in as a selection only when exactly one bit is low; any other en_in value is "no selection".
REQ-012 SHALL implement states IDLE, SETTLE, HOLD.
REQ-013 IDLE: on a selection, load stability counter with 1, register en_in/seg_in, go to SETTLE.
REQ-014 SETTLE: if en_in and seg_in both equal the registered values, increment counter; on reaching STABLE_CYCLES, capture and go to HOLD.
REQ-015 SETTLE: on a changed value with a selection, reload counter to 1 with the new values; on no selection, go to IDLE.
REQ-016 HOLD: no recapture while en_in/seg_in are unchanged; changed seg_in with the same selection returns to SETTLE (recapture overwrites that digit); a new selection enters SETTLE; no selection goes to IDLE.
REQ-017 Capture latency SHALL be exactly STABLE_CYCLES clocks from the first cycle of a stable selection; with STABLE_CYCLES=1, capture occurs on that first clock.
REQ-018 Capture SHALL decode seg_in via the standard hex table (e.g. 0x01->0, 0x4F->1, 0x00->8, 0x38->F) into shadow nibble k and set digit_mask[k].
REQ-019 An undecodable pattern (including blank 0x7F) SHALL set digit_mask[k], leave shadow nibble k unchanged, and set a frame error flag.
REQ-020 When digit_mask becomes 8'hFF, the next clock SHALL copy shadow to value, pulse valid, drive frame_err from the frame error flag, and clear digit_mask and the flag.
REQ-021 A capture in that same clock SHALL count toward the new frame.
REQ-022 Recapturing an already-set digit SHALL overwrite its nibble without affecting other digits.

Reset
REQ-023 Reset low SHALL immediately force IDLE, value=0, valid=0, frame_err=0, digit_mask=0, shadow=0, err_count=0, counter=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; no valid pulse SHALL follow reset release without 8 fresh captures.

Configuration
REQ-025 With macro SEG7_DEC_ERRCNT_EN defined, err_count SHALL increment on each undecodable capture, saturating at 255, cleared only by reset.
REQ-026 Without SEG7_DEC_ERRCNT_EN, err_count SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-027 Package seg7_dec_pkg SHALL hold the state enum, the 16-entry active-low segment table, and the SEG_BLANK (7'h7F) constant.
REQ-028 Decoding SHALL live in combinational sub-module seg7_to_hex (seg in, nibble out, ok flag).

Verification
REQ-029 STABLE_CYCLES=4; scan digits 0..7 showing 1,2,3,4,5,6,7,8, each held 10 clocks -> single valid pulse, value=32'h87654321, frame_err=0.
REQ-030 Hold digit 3 selection but toggle seg_in every 3 clocks for 30 clocks -> digit_mask[3] never sets.
REQ-031 Full frame with digit 5 blank (0x7F) -> valid with frame_err=1, value[23:20] keeps its previous value; err_count=1 when macro defined, 0 when not.
REQ-032 en_in=8'hFC (two selected) or 8'hFF for 50 clocks -> remains IDLE, digit_mask=0.
REQ-033 Reset pulse low after 5 captures -> all outputs 0 immediately; 8 new captures needed before valid.
REQ-034 Recapture digit 0 as 'F' (0x38) after '1' within one frame -> value[3:0]=4'hF at valid.
